// File: rtl/tlut_pkg.sv
// tlut_pkg: shared widths, ramp limit and FSM state type for the ramp sweep.
//   W       ramp / result width, from `INPUT_WIDTH (default 8)
//   N       lane count, from `DIM_A (default 4)
//   RNG_MAX last ramp value, 2^W-1
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 8
`endif
`ifndef DIM_A
`define DIM_A 4
`endif

package tlut_pkg;

  localparam int unsigned W = `INPUT_WIDTH;
  localparam int unsigned N = `DIM_A;

  localparam logic [W-1:0] RNG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tlut_sweep_lane.sv
// tlut_sweep_lane: one lane's first-hit capture.
//   clear     zero the lane at the start of a sweep
//   en_d      ramp-valid, delayed to line up with hit
//   hit       registered comparator result for this lane
//   rng_d     ramp value delayed to line up with hit
//   captured  lane has latched its first hit
//   value     ramp value at the first hit
//   take_c    combinational: lane captures on this edge
module tlut_sweep_lane
  import tlut_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en_d,
  input  logic         hit,
  input  logic [W-1:0] rng_d,
  output logic         captured,
  output logic [W-1:0] value,
  output logic         take_c
);

  // First qualified hit wins; later hits are ignored.
  assign take_c = en_d & hit & ~captured;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured <= 1'b0;
      value    <= '0;
    end else if (clear) begin
      captured <= 1'b0;
      value    <= '0;
    end else if (take_c) begin
      captured <= 1'b1;
      value    <= rng_d;
    end
  end

endmodule

// File: rtl/tlut_sweep.sv
// tlut_sweep: drives a 0..2^W-1 ramp to an external comparator array and
// records, per lane, the ramp value at which that lane first hit.
//   clk, rst_n  clock, async active-low reset
//   start       begin a sweep (honoured only when idle)
//   rng         ramp value to the comparators
//   enable      ramp valid qualifier
//   hit         registered comparator results, one cycle behind rng
//   busy        high whenever not idle
//   result      per-lane captured ramp value
//   miss        per-lane "never hit" flag
//   out_valid   one-cycle pulse; result/miss held until the next start
// Build option: TLUT_SWEEP_EARLY_EXIT_EN ends the sweep as soon as every
// lane has captured.
module tlut_sweep
  import tlut_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [W-1:0]        rng,
  output logic                enable,
  input  logic [N-1:0]        hit,
  output logic                busy,
  output logic [N-1:0][W-1:0] result,
  output logic [N-1:0]        miss,
  output logic                out_valid
);

  state_t       state_q, state_n;
  logic [W-1:0] rng_n;
  logic [W-1:0] rng_d;
  logic         enable_n;
  logic         en_d;
  logic         busy_n;
  logic         out_valid_n;
  logic [N-1:0] miss_n;
  logic         clear_c;
  logic [N-1:0] captured;
  logic [N-1:0] take_c;
  logic [N-1:0] cap_next_c;

  // Per-lane capture registers.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    tlut_sweep_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear_c),
      .en_d     (en_d),
      .hit      (hit[i]),
      .rng_d    (rng_d),
      .captured (captured[i]),
      .value    (result[i]),
      .take_c   (take_c[i])
    );
  end

  // Captured state as it will be after this edge, so a hit landing on the
  // final cycle still counts toward miss and early exit.
  assign cap_next_c = captured | take_c;

`ifdef TLUT_SWEEP_EARLY_EXIT_EN
  logic all_cap_c;
  assign all_cap_c = &cap_next_c;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    rng_n       = rng;
    enable_n    = enable;
    out_valid_n = 1'b0;
    miss_n      = miss;
    clear_c     = 1'b0;
    case (state_q)
      IDLE: begin
        rng_n    = '0;
        enable_n = 1'b0;
        if (start) begin
          state_n  = SWEEP;
          enable_n = 1'b1;
          miss_n   = '0;
          clear_c  = 1'b1;
        end
      end
      SWEEP: begin
        enable_n = 1'b1;
        // Stop on the last ramp value instead of wrapping with enable high.
        if (rng == RNG_MAX) begin
          state_n  = DRAIN;
          enable_n = 1'b0;
        end else begin
          rng_n = rng + W'(1);
        end
`ifdef TLUT_SWEEP_EARLY_EXIT_EN
        if (all_cap_c) begin
          state_n     = DONE;
          enable_n    = 1'b0;
          miss_n      = ~cap_next_c;
          out_valid_n = 1'b1;
        end
`endif
      end
      DRAIN: begin
        // One extra cycle so the hit for RNG_MAX is captured.
        state_n     = DONE;
        enable_n    = 1'b0;
        miss_n      = ~cap_next_c;
        out_valid_n = 1'b1;
      end
      DONE: begin
        state_n  = IDLE;
        enable_n = 1'b0;
        rng_n    = '0;
      end
      default: begin
        state_n  = IDLE;
        enable_n = 1'b0;
        rng_n    = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs; rng_d/en_d align the ramp with hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rng       <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      miss      <= '0;
      rng_d     <= '0;
      en_d      <= 1'b0;
    end else begin
      state_q   <= state_n;
      rng       <= rng_n;
      enable    <= enable_n;
      busy      <= busy_n;
      out_valid <= out_valid_n;
      miss      <= miss_n;
      rng_d     <= rng;
      en_d      <= enable;
    end
  end

endmodule

// File: tb/tb_tlut_sweep.sv
// tb_tlut_sweep: scoreboard bench for tlut_sweep with a registered
// comparator model (W=8, N=4).
module tb_tlut_sweep;
  import tlut_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [W-1:0]        rng;
  logic                enable;
  logic [N-1:0]        hit;
  logic                busy;
  logic [N-1:0][W-1:0] result;
  logic [N-1:0]        miss;
  logic                out_valid;

  tlut_sweep dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rng       (rng),
    .enable    (enable),
    .hit       (hit),
    .busy      (busy),
    .result    (result),
    .miss      (miss),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model: hit registers (rng == lane value), plus injected hits.
  logic [N-1:0][W-1:0] lane_val;
  logic [N-1:0]        lane_on;
  logic [N-1:0]        inj;
  logic                dup_on;
  logic [W-1:0]        dup_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit <= '0;
    else begin
      for (int i = 0; i < int'(N); i++)
        hit[i] <= (lane_on[i] && rng == lane_val[i]) || inj[i] ||
                  (dup_on && i == 1 && rng == dup_val);
    end
  end

  typedef struct {
    int                  cyc;
    logic [N-1:0][W-1:0] res;
    logic [N-1:0]        miss;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every out_valid pulse against the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", 64'(cyc), 64'(e.cyc));
        check("result", 64'(result), 64'(e.res));
        check("miss", 64'(miss), 64'(e.miss));
      end
    end
  end

  function automatic logic [N-1:0][W-1:0] mk(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                              input logic [W-1:0] a2, input logic [W-1:0] a3);
    mk    = '0;
    mk[0] = a0;
    mk[1] = a1;
    mk[2] = a2;
    mk[3] = a3;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  task automatic launch(input logic [N-1:0][W-1:0] vals, input logic [N-1:0] on,
                        input logic [N-1:0] inj_mask, input logic push,
                        input logic [N-1:0][W-1:0] exp_res, input logic [N-1:0] exp_miss,
                        input int lat, output int c0);
    exp_t e;
    lane_val = vals;
    lane_on  = on;
    c0       = cyc;
    if (push) begin
      e.cyc  = c0 + lat;
      e.res  = exp_res;
      e.miss = exp_miss;
      q.push_back(e);
    end
    start = 1'b1;
    inj   = inj_mask;
    @(negedge clk);
    start = 1'b0;
    inj   = '0;
  endtask

  task automatic settle(input int c_end, input string name);
    wait_cyc(c_end);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got no out_valid, expected %0d pending pulse(s)", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int c0;
    logic [N-1:0][W-1:0] v;
    rst_n    = 1'b0;
    start    = 1'b0;
    inj      = '0;
    dup_on   = 1'b0;
    dup_val  = '0;
    lane_on  = '0;
    lane_val = '0;
    repeat (2) @(negedge clk);
    check("rst_rng", 64'(rng), 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_miss", 64'(miss), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full sweep {5,0,255,77}; spurious hit on lane 3 while en_d is low.
    v = mk(8'd5, 8'd0, 8'd255, 8'd77);
    launch(v, 4'b1111, 4'b1000, 1'b1, v, 4'b0000, 258, c0);
    check("a_c1_rng", 64'(rng), 64'd0);
    check("a_c1_enable", 64'(enable), 64'd1);
    check("a_c1_busy", 64'(busy), 64'd1);
    wait_cyc(c0 + 256);
    check("a_c256_rng", 64'(rng), 64'd255);
    check("a_c256_enable", 64'(enable), 64'd1);
    wait_cyc(c0 + 257);
    check("a_drain_rng", 64'(rng), 64'd255);
    check("a_drain_enable", 64'(enable), 64'd0);
    check("a_drain_busy", 64'(busy), 64'd1);
    settle(c0 + 262, "a_done");
    check("a_idle_busy", 64'(busy), 64'd0);
    check("a_idle_rng", 64'(rng), 64'd0);
    check("a_hold_result", 64'(result), 64'(v));

    // Lane 2 never hits.
    launch(mk(8'd5, 8'd0, 8'd99, 8'd77), 4'b1011, 4'b0000, 1'b1,
           mk(8'd5, 8'd0, 8'd0, 8'd77), 4'b0100, 258, c0);
    settle(c0 + 262, "b_done");

    // Lane 1 re-hits at 200 after its true hit at 30.
    dup_on  = 1'b1;
    dup_val = 8'd200;
    v = mk(8'd10, 8'd30, 8'd40, 8'd255);
    launch(v, 4'b1111, 4'b0000, 1'b1, v, 4'b0000, 258, c0);
    settle(c0 + 262, "c_done");
    dup_on = 1'b0;

    // start pulses at cycle 10 and in the DONE cycle are ignored.
    v = mk(8'd3, 8'd6, 8'd9, 8'd255);
    launch(v, 4'b1111, 4'b0000, 1'b1, v, 4'b0000, 258, c0);
    wait_cyc(c0 + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("d_busy_after_pulse", 64'(busy), 64'd1);
    wait_cyc(c0 + 258);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("d_no_restart", 64'(busy), 64'd0);
    settle(c0 + 264, "d_done");
    check("d_still_idle", 64'(busy), 64'd0);

    // Reset at cycle 100 abandons the sweep; a fresh start runs to completion.
    launch(mk(8'd5, 8'd0, 8'd255, 8'd77), 4'b1111, 4'b0000, 1'b0, '0, '0, 0, c0);
    wait_cyc(c0 + 100);
    rst_n = 1'b0;
    #1;
    check("e_rst_rng", 64'(rng), 64'd0);
    check("e_rst_enable", 64'(enable), 64'd0);
    check("e_rst_busy", 64'(busy), 64'd0);
    check("e_rst_out_valid", 64'(out_valid), 64'd0);
    check("e_rst_result", 64'(result), 64'd0);
    check("e_rst_miss", 64'(miss), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(c0 + 400);
    v = mk(8'd11, 8'd22, 8'd33, 8'd255);
    launch(v, 4'b1111, 4'b0000, 1'b1, v, 4'b0000, 258, c0);
    settle(c0 + 262, "e_done");

`ifdef TLUT_SWEEP_EARLY_EXIT_EN
    // Early exit once all lanes capture.
    v = mk(8'd1, 8'd2, 8'd3, 8'd4);
    launch(v, 4'b1111, 4'b0000, 1'b1, v, 4'b0000, 7, c0);
    wait_cyc(c0 + 6);
    check("f_c6_enable", 64'(enable), 64'd1);
    wait_cyc(c0 + 7);
    check("f_c7_enable", 64'(enable), 64'd0);
    settle(c0 + 10, "f_done");
    check("f_idle_busy", 64'(busy), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
